// File: rtl/teclado_entrada_bcd_pkg.sv
// Shared keypad definitions: row/column codes, key classes and the (lin,col) decode function.
package teclado_entrada_bcd_pkg;

  localparam logic [3:0] LIN_TOP = 4'b1000;
  localparam logic [3:0] LIN_MID1 = 4'b0100;
  localparam logic [3:0] LIN_MID2 = 4'b0010;
  localparam logic [3:0] LIN_BOT = 4'b0001;
  localparam logic [3:0] COL_IZQ = 4'b1000;
  localparam logic [3:0] COL_MID1 = 4'b0100;
  localparam logic [3:0] COL_MID2 = 4'b0010;
  localparam logic [3:0] COL_DIR = 4'b0001;

  typedef enum logic [2:0] {
    KEY_DIG,
    KEY_ENT,
    KEY_CLR,
    KEY_DEL,
    KEY_NOP,
    KEY_ERR
  } key_class_e;

  typedef struct packed {
    key_class_e  cls;
    logic [3:0]  digit;
  } key_t;

  typedef enum logic [1:0] {
    StIdle,
    StDeb,
    StHeld
  } deb_state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (v)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Upper 3x3 block holds 1..9 row-major; right column is A/B/C/D, bottom row is * 0 # D.
  function automatic key_t decode_key(input logic [3:0] lin, input logic [3:0] col);
    key_t       k;
    logic [1:0] r;
    logic [1:0] c;
    k.cls   = KEY_NOP;
    k.digit = 4'd0;
    r = onehot_idx(lin);
    c = onehot_idx(col);
    if (!is_onehot4(lin) || !is_onehot4(col)) begin
      k.cls = KEY_ERR;
    end else if (r == 2'd3) begin
      unique case (c)
        2'd0: k.cls = KEY_CLR;
        2'd1: k.cls = KEY_DIG;
        2'd2: k.cls = KEY_ENT;
        default: k.cls = KEY_DEL;
      endcase
    end else if (c != 2'd3) begin
      k.cls   = KEY_DIG;
      k.digit = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return k;
  endfunction

endpackage

// File: rtl/teclado_debounce.sv
// Key-press debouncer: 2-FF synchroniser, DEB_CYC-cycle stability counter, IDLE/DEB/HELD FSM.
module teclado_debounce
  import teclado_entrada_bcd_pkg::*;
#(
  parameter int unsigned DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bot_press,
  output logic key_acc
);

  localparam int unsigned CntW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYC - 1);

  logic            bp_meta_q;
  logic            bp_sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  deb_state_e      state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_meta_q <= 1'b0;
      bp_sync_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= StIdle;
    end else begin
      bp_meta_q <= bot_press;
      bp_sync_q <= bp_meta_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_acc = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bp_sync_q) state_d = StDeb;
      end
      StDeb: begin
        if (!bp_sync_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StHeld;
          cnt_d   = '0;
          key_acc = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        // Stay here until release so a held key never auto-repeats.
        if (!bp_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/teclado_entrada_bcd.sv
// Calculator-style BCD number entry from a debounced 4x4 keypad.
// Optional inactivity clear is built only when TECLADO_TIMEOUT_EN is defined.
module teclado_entrada_bcd
  import teclado_entrada_bcd_pkg::*;
#(
  parameter int unsigned NDIG    = 3,
  parameter int unsigned DEB_CYC = 16,
  parameter int unsigned TO_CYC  = 50000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  lin,
  input  logic [3:0]                  col,
  input  logic                        bot_press,
  output logic [4*NDIG-1:0]           s,
  output logic                        s_valid,
  output logic [4*NDIG-1:0]           ent,
  output logic [$clog2(NDIG+1)-1:0]   n_dig,
  output logic                        ovf,
  output logic                        key_err,
  output logic                        timeout
);

  localparam int unsigned EntW = 4 * NDIG;
  localparam int unsigned NW   = $clog2(NDIG + 1);
  localparam logic [NW-1:0] NdigMax = NW'(NDIG);

  logic            key_acc;
  key_t            key;
  logic            to_hit;
  logic [EntW-1:0] s_q, s_d, ent_q, ent_d;
  logic [NW-1:0]   ndig_q, ndig_d;
  logic            ovf_q, ovf_d;
  logic            s_valid_q, s_valid_d;
  logic            key_err_q, key_err_d;
  logic            timeout_q, timeout_d;

  teclado_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .bot_press (bot_press),
    .key_acc   (key_acc)
  );

  assign key = decode_key(lin, col);

`ifdef TECLADO_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  assign to_hit = !key_acc && (ndig_q != '0) && (idle_q == 32'(TO_CYC - 1));

  always_comb begin
    idle_d = idle_q;
    if (key_acc) begin
      idle_d = '0;
    end else if (ndig_q != '0) begin
      idle_d = to_hit ? '0 : idle_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = TO_CYC;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    s_d       = s_q;
    ent_d     = ent_q;
    ndig_d    = ndig_q;
    ovf_d     = ovf_q;
    s_valid_d = 1'b0;
    key_err_d = 1'b0;
    timeout_d = to_hit;
    if (key_acc) begin
      unique case (key.cls)
        KEY_DIG: begin
          if (ndig_q < NdigMax) begin
            ent_d  = (ent_q << 4) | EntW'(key.digit);
            ndig_d = ndig_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        KEY_ENT: begin
          s_d       = ent_q;
          s_valid_d = 1'b1;
          ent_d     = '0;
          ndig_d    = '0;
          ovf_d     = 1'b0;
        end
        KEY_CLR: begin
          ent_d  = '0;
          ndig_d = '0;
          ovf_d  = 1'b0;
        end
        KEY_DEL: begin
          if (ndig_q != '0) begin
            ent_d  = ent_q >> 4;
            ndig_d = ndig_q - 1'b1;
          end
        end
        KEY_ERR: key_err_d = 1'b1;
        default: ;
      endcase
    end else if (to_hit) begin
      ent_d  = '0;
      ndig_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      ent_q     <= '0;
      ndig_q    <= '0;
      ovf_q     <= 1'b0;
      s_valid_q <= 1'b0;
      key_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      ent_q     <= ent_d;
      ndig_q    <= ndig_d;
      ovf_q     <= ovf_d;
      s_valid_q <= s_valid_d;
      key_err_q <= key_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign s       = s_q;
  assign ent     = ent_q;
  assign n_dig   = ndig_q;
  assign ovf     = ovf_q;
  assign s_valid = s_valid_q;
  assign key_err = key_err_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_teclado_entrada_bcd.sv
// Self-checking bench for teclado_entrada_bcd: directed keypad scenarios plus random key streams
// compared against a digit-queue reference model.
module tb_teclado_entrada_bcd;

  localparam int unsigned NDIG    = 3;
  localparam int unsigned DEB_CYC = 4;
  localparam int unsigned TO_CYC  = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  lin = 4'b0000;
  logic [3:0]  col = 4'b0000;
  logic        bot_press = 1'b0;
  logic [11:0] s;
  logic        s_valid;
  logic [11:0] ent;
  logic [1:0]  n_dig;
  logic        ovf;
  logic        key_err;
  logic        timeout;

  teclado_entrada_bcd #(
    .NDIG    (NDIG),
    .DEB_CYC (DEB_CYC),
    .TO_CYC  (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lin       (lin),
    .col       (col),
    .bot_press (bot_press),
    .s         (s),
    .s_valid   (s_valid),
    .ent       (ent),
    .n_dig     (n_dig),
    .ovf       (ovf),
    .key_err   (key_err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sv_cnt = 0;
  int ke_cnt = 0;
  int to_cnt = 0;

  always @(negedge clk) begin
    if (s_valid) sv_cnt++;
    if (key_err) ke_cnt++;
    if (timeout) to_cnt++;
  end

  // Reference model: the entry is a list of digits, oldest first.
  int          q[$];
  logic [11:0] m_s = 12'h000;
  logic        m_ovf = 1'b0;
  int          exp_sv = 0;
  int          exp_ke = 0;
  int          exp_to = 0;
  string       keys = "123A456B789C*0#D";

  function automatic logic [11:0] m_ent();
    logic [31:0] v;
    v = 0;
    foreach (q[i]) v = (v << 4) | q[i];
    return v[11:0];
  endfunction

  task automatic model_key(input byte ch);
    if (ch >= "0" && ch <= "9") begin
      if (q.size() < NDIG) q.push_back(int'(ch - "0"));
      else m_ovf = 1'b1;
    end else if (ch == "#") begin
      m_s = m_ent();
      exp_sv++;
      q.delete();
      m_ovf = 1'b0;
    end else if (ch == "*") begin
      q.delete();
      m_ovf = 1'b0;
    end else if (ch == "D") begin
      if (q.size() > 0) void'(q.pop_back());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic verify(input string tag);
    chk({tag, "_ent"}, 32'(ent), 32'(m_ent()));
    chk({tag, "_ndig"}, 32'(n_dig), 32'(q.size()));
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, "_s"}, 32'(s), 32'(m_s));
    chk({tag, "_svcnt"}, 32'(sv_cnt), 32'(exp_sv));
    chk({tag, "_kecnt"}, 32'(ke_cnt), 32'(exp_ke));
    chk({tag, "_tocnt"}, 32'(to_cnt), 32'(exp_to));
  endtask

  function automatic int key_idx(input byte ch);
    for (int i = 0; i < 16; i++) if (keys[i] == ch) return i;
    return 0;
  endfunction

  task automatic drive_key(input int k);
    logic [3:0] base;
    base = 4'b1000;
    lin  = base >> (k / 4);
    col  = base >> (k % 4);
  endtask

  task automatic press_raw(input int hold);
    bot_press = 1'b1;
    repeat (hold) @(negedge clk);
    bot_press = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_ch(input byte ch, input int hold);
    drive_key(key_idx(ch));
    press_raw(hold);
    model_key(ch);
  endtask

  initial begin
    logic [3:0] bad_codes [4];
    bad_codes[0] = 4'b0110;
    bad_codes[1] = 4'b0000;
    bad_codes[2] = 4'b1111;
    bad_codes[3] = 4'b1010;

    repeat (3) @(negedge clk);
    verify("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: latency of the first key, then 1,2,3,#
    drive_key(key_idx("1"));
    bot_press = 1'b1;
    repeat (6) @(negedge clk);
    chk("lat_before", 32'(ent), 32'h000);
    @(negedge clk);
    chk("lat_after", 32'(ent), 32'h001);
    repeat (3) @(negedge clk);
    bot_press = 1'b0;
    repeat (4) @(negedge clk);
    model_key("1");
    verify("t1_1");
    press_ch("2", 8);
    verify("t1_2");
    press_ch("3", 8);
    verify("t1_3");
    press_ch("#", 8);
    chk("t1_s", 32'(s), 32'h123);
    verify("t1_ent");

    // 2: overflow drops the fourth digit
    press_ch("4", 8);
    press_ch("5", 8);
    press_ch("6", 8);
    press_ch("7", 8);
    chk("t2_ovf", 32'(ovf), 32'h1);
    verify("t2_full");
    press_ch("#", 8);
    chk("t2_s", 32'(s), 32'h456);
    verify("t2_ent");

    // 3: delete, including past empty
    press_ch("9", 8);
    press_ch("8", 8);
    press_ch("D", 8);
    chk("t3_ent", 32'(ent), 32'h009);
    verify("t3_del1");
    press_ch("D", 8);
    press_ch("D", 8);
    verify("t3_empty");

    // 4: short glitch ignored, long hold gives exactly one digit
    drive_key(key_idx("7"));
    press_raw(3);
    verify("t4_glitch");
    press_ch("7", 100);
    verify("t4_hold");

    // 5: non-one-hot row
    lin = 4'b0110;
    col = 4'b0001;
    press_raw(8);
    exp_ke++;
    verify("t5_keyerr");

    // 6: empty commit, clear, and A/B/C ignored
    press_ch("*", 8);
    press_ch("A", 8);
    press_ch("C", 8);
    press_ch("#", 8);
    verify("t6_empty_commit");

`ifdef TECLADO_TIMEOUT_EN
    press_ch("5", 8);
    repeat (60) @(negedge clk);
    q.delete();
    m_ovf = 1'b0;
    exp_to++;
    verify("t7_timeout");
`endif

    // Random key stream with occasional malformed codes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        lin = bad_codes[$urandom_range(0, 3)];
        col = 4'b1000 >> $urandom_range(0, 3);
        press_raw(int'($urandom_range(6, 20)));
        exp_ke++;
      end else begin
        press_ch(keys[$urandom_range(0, 15)], int'($urandom_range(6, 20)));
      end
      verify("rand");
    end

    // Reset in the middle of debounce and entry
    press_ch("3", 8);
    drive_key(key_idx("4"));
    bot_press = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_s = 12'h000;
    m_ovf = 1'b0;
    chk("rst_svalid", 32'(s_valid), 32'h0);
    chk("rst_keyerr", 32'(key_err), 32'h0);
    verify("rst_mid");
    bot_press = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    verify("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
